// File: rtl/oam_dma.sv
// OAM DMA engine. A CPU write to the DMA control register latches a source
// page. The engine then copies OAM_BYTES consecutive bytes from that page
// into OAM, one byte per CYCLES_PER_BYTE clocks. `active` is high for the
// whole transfer so that the bus arbiter can block CPU access to the source.
//
// Handshake: there is no valid/ready flow control. The source port is read
// combinationally: `dma_read_en` and `dma_addr` are held for a whole byte slot,
// and `dma_rdata` must be valid in the same cycle. The OAM port is a
// fire-and-forget strobe: `oam_write_en` is high for exactly one clock per byte.
module oam_dma #(
   parameter int          CYCLES_PER_BYTE = 4,
   parameter int          OAM_BYTES       = 160,
   parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_write_en,
   input  logic        cpu_read_en,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] dma_addr,
   output logic        dma_read_en,
   input  logic [7:0]  dma_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_write_en,
   output logic        active
);

   // A sub-counter of at least one bit keeps CYCLES_PER_BYTE == 1 legal.
   localparam int SUB_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]       IDX_LAST = 8'(OAM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [SUB_W-1:0] sub, sub_nxt;
   logic [7:0]       idx, idx_nxt;
   logic [7:0]       page;
   logic             reg_sel;
   logic             reg_wr;
   logic [15:0]      base;

   assign reg_sel = (cpu_addr == DMA_REG_ADDR);
   assign reg_wr  = cpu_write_en && reg_sel;

   // Pages 0xE0 and up are echo RAM; fold them back onto work RAM.
   assign base = (page >= 8'hE0) ? {page & 8'hDF, 8'h00} : {page, 8'h00};

   // Register readback is combinational and shows the page from the last edge.
   assign cpu_rdata = (cpu_read_en && reg_sel) ? page : 8'hFF;

   assign active = (state != IDLE);

   // Control register: latches the source page on every CPU write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         page <= 8'hFF;
      end else if (reg_wr) begin
         page <= cpu_wdata;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sub   <= '0;
         idx   <= 8'h00;
      end else begin
         state <= state_nxt;
         sub   <= sub_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state logic; a register write restarts from SETUP in any state.
   always_comb begin
      state_nxt = state;
      sub_nxt   = sub;
      idx_nxt   = idx;
      unique case (state)
         IDLE: begin
            sub_nxt = '0;
            idx_nxt = 8'h00;
         end
         SETUP: begin
            if (sub == SUB_LAST) begin
               state_nxt = XFER;
               sub_nxt   = '0;
               idx_nxt   = 8'h00;
            end else begin
               sub_nxt = sub + 1'b1;
            end
         end
         XFER: begin
            if (sub == SUB_LAST) begin
               sub_nxt = '0;
               if (idx == IDX_LAST) begin
                  state_nxt = IDLE;
                  idx_nxt   = 8'h00;
               end else begin
                  idx_nxt = idx + 8'd1;
               end
            end else begin
               sub_nxt = sub + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            sub_nxt   = '0;
            idx_nxt   = 8'h00;
         end
      endcase
      if (reg_wr) begin
         state_nxt = SETUP;
         sub_nxt   = '0;
         idx_nxt   = 8'h00;
      end
   end

   // Datapath outputs: driven only in XFER, idle values otherwise. The final
   // byte of a slot is still written when a restart lands on the same edge.
   always_comb begin
      dma_read_en  = 1'b0;
      dma_addr     = 16'h0000;
      oam_write_en = 1'b0;
      oam_addr     = 8'h00;
      oam_wdata    = 8'h00;
      if (state == XFER) begin
         dma_read_en  = 1'b1;
         dma_addr     = base + {8'h00, idx};
         oam_write_en = (sub == SUB_LAST);
         oam_addr     = idx;
         oam_wdata    = dma_rdata;
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: a default-parameter instance and a small instance
// (one clock per byte, four bytes), both compared every cycle against a
// timing model derived from the write edge, plus decode vectors and
// directed multi-cycle sequences.
module tb_oam_dma;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_write_en, cpu_read_en;
   logic [7:0]  cpu_rdata;
   logic [15:0] dma_addr;
   logic        dma_read_en;
   logic [7:0]  dma_rdata;
   logic [7:0]  oam_addr, oam_wdata;
   logic        oam_write_en, active;

   logic [15:0] s_cpu_addr;
   logic [7:0]  s_cpu_wdata;
   logic        s_cpu_write_en, s_cpu_read_en;
   logic [7:0]  s_cpu_rdata;
   logic [15:0] s_dma_addr;
   logic        s_dma_read_en;
   logic [7:0]  s_dma_rdata;
   logic [7:0]  s_oam_addr, s_oam_wdata;
   logic        s_oam_write_en, s_active;

   // Source memory stand-in: combinational, data derived from the address.
   assign dma_rdata   = dma_addr[7:0] ^ 8'h5A;
   assign s_dma_rdata = s_dma_addr[7:0] ^ 8'h5A;

   oam_dma u_dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
      .cpu_rdata(cpu_rdata),
      .dma_addr(dma_addr), .dma_read_en(dma_read_en), .dma_rdata(dma_rdata),
      .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write_en(oam_write_en),
      .active(active)
   );

   oam_dma #(.CYCLES_PER_BYTE(1), .OAM_BYTES(4)) u_small (
      .clk(clk), .reset(reset),
      .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
      .cpu_write_en(s_cpu_write_en), .cpu_read_en(s_cpu_read_en),
      .cpu_rdata(s_cpu_rdata),
      .dma_addr(s_dma_addr), .dma_read_en(s_dma_read_en), .dma_rdata(s_dma_rdata),
      .oam_addr(s_oam_addr), .oam_wdata(s_oam_wdata), .oam_write_en(s_oam_write_en),
      .active(s_active)
   );

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Outputs are a pure function of the clocks elapsed since the starting
   // write edge: SETUP lasts cpb clocks, then each byte takes cpb clocks and
   // is stored on the last clock of its slot.
   typedef struct packed {
      logic        act;
      logic        rd;
      logic [15:0] daddr;
      logic        we;
      logic [7:0]  oaddr;
      logic [7:0]  wdata;
   } out_t;

   function automatic out_t model_out(input int cpb, input int nbytes, input bit started,
                                      input int t, input logic [7:0] pg);
      out_t        o;
      int          k;
      logic [15:0] src_base;
      o = '0;
      src_base = (pg >= 8'hE0) ? {pg - 8'h20, 8'h00} : {pg, 8'h00};
      if (started && t >= 0 && t < cpb * (nbytes + 1)) begin
         o.act = 1'b1;
         if (t >= cpb) begin
            k       = (t - cpb) / cpb;
            o.rd    = 1'b1;
            o.daddr = src_base + 16'(k);
            o.oaddr = 8'(k);
            o.wdata = o.daddr[7:0] ^ 8'h5A;
            o.we    = ((t + 1) % cpb) == 0;
         end
      end
      return o;
   endfunction

   int         n = 0;                 // rising edges seen
   bit         b_started = 0, s_started = 0;
   int         b_e0 = 0, s_e0 = 0;
   logic [7:0] b_page = 8'hFF, s_page = 8'hFF;

   // scoreboard of expected OAM writes {oam_addr, oam_wdata}
   logic [15:0] exp_q[$];

   int          act_cnt, wr_cnt;
   bit          have_src, have_wr, saw50;
   logic [15:0] first_src, first_wr_src;
   logic [7:0]  first_wr_addr;
   int          first_wr_n;

   // Compare both instances against the model; call between edges.
   task automatic check_now();
      out_t        exp_o, got_o;
      logic [15:0] item;
      exp_o = model_out(4, 160, b_started, n - b_e0, b_page);
      got_o = {active, dma_read_en, dma_addr, oam_write_en, oam_addr, oam_wdata};
      check("big_outputs", 64'(got_o), 64'(exp_o));
      check("big_rdata", 64'(cpu_rdata),
            64'((cpu_read_en && cpu_addr == 16'hFF46) ? b_page : 8'hFF));
      if (exp_o.we) exp_q.push_back({exp_o.oaddr, exp_o.wdata});
      if (oam_write_en === 1'b1) begin
         if (exp_q.size() == 0) check("sb_unexpected_write", 64'(1), 64'(0));
         else begin
            item = exp_q.pop_front();
            check("sb_oam_write", 64'({oam_addr, oam_wdata}), 64'(item));
         end
      end

      exp_o = model_out(1, 4, s_started, n - s_e0, s_page);
      got_o = {s_active, s_dma_read_en, s_dma_addr, s_oam_write_en, s_oam_addr, s_oam_wdata};
      check("small_outputs", 64'(got_o), 64'(exp_o));
      check("small_rdata", 64'(s_cpu_rdata),
            64'((s_cpu_read_en && s_cpu_addr == 16'hFF46) ? s_page : 8'hFF));

      if (active === 1'b1) act_cnt++;
      if (oam_write_en === 1'b1) begin
         wr_cnt++;
         if (oam_addr == 8'd50) saw50 = 1;
         if (!have_wr) begin
            have_wr = 1; first_wr_n = n; first_wr_src = dma_addr; first_wr_addr = oam_addr;
         end
      end
      if (dma_read_en === 1'b1 && !have_src) begin
         have_src = 1; first_src = dma_addr;
      end
   endtask

   // Rising edge: the model samples the same inputs the DUTs sample.
   task automatic advance();
      @(posedge clk);
      n++;
      if (reset && cpu_write_en && cpu_addr == 16'hFF46) begin
         b_started = 1; b_e0 = n; b_page = cpu_wdata;
      end
      if (reset && s_cpu_write_en && s_cpu_addr == 16'hFF46) begin
         s_started = 1; s_e0 = n; s_page = s_cpu_wdata;
      end
      #1;
      cpu_write_en   = 1'b0;
      cpu_read_en    = 1'b0;
      s_cpu_write_en = 1'b0;
      s_cpu_read_en  = 1'b0;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_now();
      advance();
   endtask

   task automatic clear_stats();
      act_cnt = 0; wr_cnt = 0; have_src = 0; have_wr = 0; saw50 = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_wdata = d; cpu_write_en = 1'b1;
      cycle();
   endtask

   task automatic small_write(input logic [15:0] a, input logic [7:0] d);
      s_cpu_addr = a; s_cpu_wdata = d; s_cpu_write_en = 1'b1;
      cycle();
   endtask

   // ---------------- decode vectors ----------------
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        we;
      logic        re;
      logic [7:0]  exp_rdata;
      logic        exp_active;
   } vec_t;

   vec_t vecs[9];

   // small instance expectations for the 7 cycles after its write edge
   logic       sm_act [7];
   logic       sm_we  [7];
   logic [7:0] sm_oa  [7];

   // ---------------- main sequence ----------------
   initial begin
      int          i;
      int          e1;
      int          r;
      logic [15:0] ra;

      reset = 1'b0;
      cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_write_en = 1'b0; cpu_read_en = 1'b0;
      s_cpu_addr = 16'h0000; s_cpu_wdata = 8'h00; s_cpu_write_en = 1'b0; s_cpu_read_en = 1'b0;
      clear_stats();

      vecs[0] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
      vecs[1] = '{16'hFF47, 8'h12, 1'b1, 1'b0, 8'hFF, 1'b0};
      vecs[2] = '{16'hFF47, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
      vecs[3] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
      vecs[4] = '{16'hFF46, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0};
      vecs[5] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
      vecs[6] = '{16'hFF46, 8'h3C, 1'b1, 1'b1, 8'hFF, 1'b0};
      vecs[7] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1};
      vecs[8] = '{16'hFF47, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1};

      sm_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      sm_we  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      sm_oa  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00};

      // reset held for a few cycles
      repeat (3) cycle();
      reset = 1'b1;
      repeat (2) cycle();

      // register decode / readback vectors
      for (int v = 0; v < 9; v++) begin
         cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
         cpu_write_en = vecs[v].we; cpu_read_en = vecs[v].re;
         @(negedge clk);
         check($sformatf("vec%0d_rdata", v), 64'(cpu_rdata), 64'(vecs[v].exp_rdata));
         check($sformatf("vec%0d_active", v), 64'(active), 64'(vecs[v].exp_active));
         check_now();
         advance();
      end
      repeat (660) cycle();

      // basic transfer from 0xC100
      cpu_write(16'hFF46, 8'hC1);
      clear_stats();
      repeat (700) cycle();
      check("basic_writes", 64'(wr_cnt), 64'(160));
      check("basic_active_clocks", 64'(act_cnt), 64'(644));
      check("basic_first_src", 64'(first_src), 64'(16'hC100));

      // echo page folds onto work RAM
      cpu_write(16'hFF46, 8'hE3);
      clear_stats();
      cpu_addr = 16'hFF46; cpu_read_en = 1'b1;
      @(negedge clk);
      check("echo_readback", 64'(cpu_rdata), 64'(8'hE3));
      check_now();
      advance();
      repeat (700) cycle();
      check("echo_first_src", 64'(first_src), 64'(16'hC300));
      check("echo_writes", 64'(wr_cnt), 64'(160));

      // restart on the edge after byte 50 is written
      cpu_write(16'hFF46, 8'hC1);
      clear_stats();
      i = 0;
      while (!saw50 && i < 1000) begin
         cycle();
         i++;
      end
      check("restart_saw_byte50", 64'(saw50), 64'(1));
      cpu_write(16'hFF46, 8'h80);
      e1 = n;
      clear_stats();
      repeat (700) cycle();
      check("restart_first_write_delay", 64'(first_wr_n - e1), 64'(7));
      check("restart_first_src", 64'(first_wr_src), 64'(16'h8000));
      check("restart_first_oam_addr", 64'(first_wr_addr), 64'(8'h00));
      check("restart_writes", 64'(wr_cnt), 64'(160));
      check("restart_active_clocks", 64'(act_cnt), 64'(644));

      // asynchronous reset in the middle of XFER, between edges
      cpu_write(16'hFF46, 8'hC1);
      repeat (100) cycle();
      #1 reset = 1'b0;
      b_started = 0; b_page = 8'hFF;
      s_started = 0; s_page = 8'hFF;
      #1;
      check("areset_active", 64'(active), 64'(0));
      check("areset_dma_read_en", 64'(dma_read_en), 64'(0));
      check("areset_oam_write_en", 64'(oam_write_en), 64'(0));
      cpu_addr = 16'hFF46; cpu_read_en = 1'b1;
      #1;
      check("areset_readback", 64'(cpu_rdata), 64'(8'hFF));
      cycle();
      reset = 1'b1;
      clear_stats();
      repeat (200) cycle();
      check("areset_no_writes", 64'(wr_cnt), 64'(0));
      check("areset_no_active", 64'(act_cnt), 64'(0));

      // small instance: one clock per byte, four bytes from page 0x00
      small_write(16'hFF46, 8'h00);
      for (int t = 0; t < 7; t++) begin
         @(negedge clk);
         check($sformatf("small_t%0d_active", t), 64'(s_active), 64'(sm_act[t]));
         check($sformatf("small_t%0d_we", t), 64'(s_oam_write_en), 64'(sm_we[t]));
         if (sm_we[t]) begin
            check($sformatf("small_t%0d_oam_addr", t), 64'(s_oam_addr), 64'(sm_oa[t]));
            check($sformatf("small_t%0d_src", t), 64'(s_dma_addr), 64'({8'h00, sm_oa[t]}));
         end
         check_now();
         advance();
      end

      // randomized traffic on both instances
      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 899);
         if (r == 0) begin
            cpu_addr = 16'hFF46; cpu_wdata = 8'($urandom_range(0, 255)); cpu_write_en = 1'b1;
         end else if (r < 40) begin
            ra = 16'($urandom_range(0, 65535));
            if (ra == 16'hFF46) ra = 16'hFF45;
            cpu_addr = ra; cpu_wdata = 8'($urandom_range(0, 255)); cpu_write_en = 1'b1;
         end else begin
            cpu_addr = ($urandom_range(0, 1) == 0) ? 16'hFF46 : 16'($urandom_range(0, 65535));
            cpu_read_en = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 7) == 0) begin
            s_cpu_addr = ($urandom_range(0, 3) != 0) ? 16'hFF46 : 16'hFF47;
            s_cpu_wdata = 8'($urandom_range(0, 255));
            s_cpu_write_en = 1'b1;
         end else begin
            s_cpu_addr = 16'hFF46;
            s_cpu_read_en = 1'($urandom_range(0, 1));
         end
         cycle();
      end
      repeat (700) cycle();
      check("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // run-time bound
   initial begin
      #5_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine that sits directly downstream of the cartridge ROM and work RAM on the system bus. A CPU write to register 0xFF46 starts the block. It then reads 160 consecutive bytes from `{page, 8'h00}` through a dedicated master read port and writes each byte into OAM (0xFE00–0xFE9F) through a dedicated OAM write port. While a transfer runs, `active` tells the bus arbiter to block CPU access to the source memories.

## Interface

Parameters:
- `CYCLES_PER_BYTE`, default 4: clocks per transferred byte (one M-cycle).
- `OAM_BYTES`, default 160: bytes per transfer.
- `DMA_REG_ADDR`, default 16'hFF46: address of the control register.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  16  CPU bus address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_write_en`  in  1  CPU write strobe.
- `cpu_read_en`  in  1  CPU read strobe.
- `cpu_rdata`  out  8  register readback, combinational; 8'hFF when not selected.
- `dma_addr`  out  16  source address to ROM/RAM.
- `dma_read_en`  out  1  source read strobe.
- `dma_rdata`  in  8  source data, combinational in the same cycle (matches ROM read path).
- `oam_addr`  out  8  OAM byte index.
- `oam_wdata`  out  8  OAM write data.
- `oam_write_en`  out  1  OAM write strobe, one clock per byte.
- `active`  out  1  high from the register write until the last byte is written.

## Operation

- Register `page` (8 bits), reset value 8'hFF.
  - Written when `cpu_write_en && cpu_addr == DMA_REG_ADDR`.
  - Read data is `page` when `cpu_read_en && cpu_addr == DMA_REG_ADDR`; otherwise 8'hFF.
- Source base: `{page & 8'hDF, 8'h00}` when `page >= 8'hE0` (echo maps to 0xC000–0xDF00); otherwise `{page, 8'h00}`.
- State machine states: IDLE, SETUP, XFER.
  - IDLE → SETUP on a register write.
  - SETUP → XFER after `CYCLES_PER_BYTE` clocks.
  - XFER → IDLE after byte `OAM_BYTES-1` is written.
  - A register write in SETUP or XFER restarts the transfer: new base, byte index 0, state SETUP, sub-counter 0. `active` stays high throughout.
- Counters:
  - `sub`: 0..CYCLES_PER_BYTE-1, wraps.
  - `idx`: 8 bits, 0..OAM_BYTES-1.
  - `idx` increments only on the `sub` wrap in XFER. No wrap past OAM_BYTES-1; the transfer ends there.
- In XFER:
  - `dma_read_en` = 1 and `dma_addr` = base + `idx` (16-bit add, no carry out of bit 15 possible) for the whole byte slot.
  - `oam_write_en` = 1 only on the clock where `sub == CYCLES_PER_BYTE-1`.
  - `oam_addr` = `idx`, `oam_wdata` = `dma_rdata`.
- Outside XFER: `dma_read_en` = 0, `dma_addr` = 16'h0000, `oam_write_en` = 0, `oam_addr` = 8'h00, `oam_wdata` = 8'h00.
- `active` = (state != IDLE).
- Reset low, at any time including mid-transfer:
  - Immediately and without a clock edge: state IDLE, `sub` = 0, `idx` = 0, `page` = 8'hFF.
  - All outputs take their idle values, `active` = 0.
  - No partial OAM write after reset is asserted.

## Timing

- A register write sampled at edge E0 makes `active` = 1 after E0.
- SETUP occupies clocks E0..E0+CPB. Byte k is written to OAM at edge E0 + CPB·(k+2).
- The last byte (k = OAM_BYTES-1) is written at E0 + CPB·(OAM_BYTES+1). `active` falls after that edge.
  - Defaults: 644 clocks from E0.
- Restart with a write at E1: the timing above applies relative to E1. Bytes already written stay in OAM.
- A write and the final byte slot on the same edge: the restart wins. The final byte is still written on that edge, and the state goes to SETUP, not IDLE.
- `cpu_rdata` has zero latency and reflects `page` as updated by the previous edge.

## Test plan

- **Basic transfer.** Reset, write 0xC1 to 0xFF46. Bench returns `dma_rdata = dma_addr[7:0] ^ 8'h5A`.
  - Expect 160 OAM writes at edges E0+8, E0+12, … E0+644.
  - `oam_addr` 0x00..0x9F, source 0xC100..0xC19F, data matches.
  - `active` high for exactly 644 clocks.
- **Echo mapping.** Write 0xE3.
  - Expect source range 0xC300..0xC39F.
  - Readback of 0xFF46 returns 0xE3.
- **Restart.** Write 0xC1, then write 0x80 at the edge after byte 50 is written.
  - Expect next OAM write at oam_addr 0x00 from 0x8000, 8 clocks after the second write.
  - 160 writes follow. `active` never drops; it falls 644 clocks after the second write.
- **Async reset.** Assert reset mid-XFER between clock edges.
  - Expect `active`, `dma_read_en` and `oam_write_en` = 0 immediately.
  - Readback 0xFF. No further OAM writes after release until the next 0xFF46 write.
- **Decode.** Write 0x12 to 0xFF47 and read 0xFF47.
  - Expect no transfer and `cpu_rdata` = 0xFF.
  - Reading 0xFF46 after reset gives 0xFF.
- **Parameter.** CYCLES_PER_BYTE = 1, OAM_BYTES = 4, write 0x00.
  - Expect 4 writes at edges E0+2..E0+5 from 0x0000..0x0003.
  - `active` high for 5 clocks.
